// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bundle of the multi-port register file: read ports,
// write ports, the issue strobe and the busy scoreboard.
interface reg_file_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output ra, we, wa, wd, iss_en, iss_addr,
    input  rd, rd_busy, busy_vec
  );

  modport slave (
    input  ra, we, wa, wd, iss_en, iss_addr,
    output rd, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard (issue sets, writeback clears, set wins).

module reg_file_mp_rdport #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                           rst,
  input  logic [AW-1:0]                  ra,
  input  logic [NREG-1:0][XLEN-1:0]      regs,
  input  logic [NREG-1:0]                busy,
  input  logic [NWR-1:0]                 we,
  input  logic [NWR-1:0][AW-1:0]         wa,
  input  logic [NWR-1:0][XLEN-1:0]       wd,
  output logic [XLEN-1:0]                rd,
  output logic                           rd_busy
);
  always_comb begin
    rd = regs[ra];
    // Ascending scan so the highest-index matching writer is the one forwarded.
    if (BYPASS) begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && wa[j] == ra) rd = wd[j];
    end
    if (ZERO_REG && ra == '0) rd = '0;
    if (rst) rd = '0;
  end

  // Scoreboard view is registered state only; an in-flight writeback is not forwarded.
  assign rd_busy = !rst && busy[ra];
endmodule

module reg_file_mp #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  logic [NRD-1:0][AW-1:0]    ra_a;
  logic [NRD-1:0][XLEN-1:0]  rd_a;
  logic [NRD-1:0]            rd_busy_a;
  logic [NWR-1:0][AW-1:0]    wa_a;
  logic [NWR-1:0][XLEN-1:0]  wd_a;
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, busy_nxt;

  assign ra_a         = bus.ra;
  assign wa_a         = bus.wa;
  assign wd_a         = bus.wd;
  assign bus.rd       = rd_a;
  assign bus.rd_busy  = rd_busy_a;
  assign bus.busy_vec = busy;

  function automatic logic wr_ok(input logic [AW-1:0] a);
    return !(ZERO_REG && a == '0);
  endfunction

  // Later ports are assigned last, so port NWR-1 wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (bus.we[j] && wr_ok(wa_a[j])) regs[wa_a[j]] <= wd_a[j];
    end
  end

  // Clear on writeback first, then set on issue: a new producer owns the register.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++)
      if (bus.we[j]) busy_nxt[wa_a[j]] = 1'b0;
    if (bus.iss_en) busy_nxt[bus.iss_addr] = 1'b1;
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    reg_file_mp_rdport #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .NWR(NWR),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .rst    (rst),
      .ra     (ra_a[k]),
      .regs   (regs),
      .busy   (busy),
      .we     (bus.we),
      .wa     (wa_a),
      .wd     (wd_a),
      .rd     (rd_a[k]),
      .rd_busy(rd_busy_a[k])
    );
  end
endmodule
